// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the microcontroller control unit.
//   - FSM state encoding
//   - instruction class codes (ir[15:12] when ir[15] = 1)
//   - ALU opcode codes (ir[14:12] when ir[15] = 0)
//   - instruction field bit positions and register-file geometry
package uc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Non-ALU instruction classes; 1101/1110 decode as NOP
    localparam logic [3:0] CLS_LDI  = 4'b1000;
    localparam logic [3:0] CLS_JMP  = 4'b1001;
    localparam logic [3:0] CLS_JZ   = 4'b1010;
    localparam logic [3:0] CLS_JC   = 4'b1011;
    localparam logic [3:0] CLS_OUT  = 4'b1100;
    localparam logic [3:0] CLS_HALT = 4'b1111;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int unsigned IR_ALU_BIT  = 15;
    localparam int unsigned IR_CLASS_HI = 15;
    localparam int unsigned IR_CLASS_LO = 12;
    localparam int unsigned IR_OP_HI    = 14;
    localparam int unsigned IR_OP_LO    = 12;
    localparam int unsigned IR_RD_HI    = 11;
    localparam int unsigned IR_RD_LO    = 10;
    localparam int unsigned IR_RS_HI    = 9;
    localparam int unsigned IR_RS_LO    = 8;
    localparam int unsigned IR_IMM_HI   = 7;
    localparam int unsigned IR_IMM_LO   = 0;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned REG_AW   = 2;

    // CMP only sets Z; every other ALU op writes its result to rd
    function automatic logic alu_writes_rd(input logic [2:0] op);
        return op != OP_CMP;
    endfunction

endpackage

// File: rtl/uc_regfile.sv
// uc_regfile: 4 x WIDTH register file.
//   clk, rst_n         : clock, async active-low reset (all registers to 0)
//   raddr_a / rdata_a  : combinational read port A
//   raddr_b / rdata_b  : combinational read port B
//   we, waddr, wdata   : synchronous write port
module uc_regfile
    import uc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/uc_control_unit.sv
// uc_control_unit: fetch/decode/execute controller for the 8-bit microcontroller.
//   clk, rst_n                         : clock, async active-low reset
//   imem_req, imem_addr                : instruction fetch request / address (= PC)
//   imem_rdata, imem_ack               : instruction word and fetch completion
//   alu_a, alu_b, alu_opcode           : registered ALU operands / opcode
//   alu_result, alu_equal, alu_carry   : combinational ALU outputs
//   out_data, out_valid                : OUT instruction port, one-cycle pulse
//   halted                             : high while in HALT
module uc_control_unit
    import uc_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned PC_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [15:0]             imem_rdata,
    input  logic                    imem_ack,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_equal,
    input  logic                    alu_carry,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    halted
);

    state_t               state, state_next;
    logic [15:0]          ir;
    logic [PC_WIDTH-1:0]  pc;
    logic                 flag_z, flag_c;

    logic                 is_alu;
    logic [3:0]           ir_class;
    logic [2:0]           ir_op;
    logic [REG_AW-1:0]    rd, rs;
    logic [7:0]           imm;

    logic                 ir_load, alu_load, exec_en;
    logic                 reg_we, z_we, c_we, out_fire, branch_taken;
    logic [WIDTH-1:0]     reg_wdata, rdata_a, rdata_b;
    logic [PC_WIDTH-1:0]  pc_next;

    assign is_alu   = ~ir[IR_ALU_BIT];
    assign ir_class = ir[IR_CLASS_HI:IR_CLASS_LO];
    assign ir_op    = ir[IR_OP_HI:IR_OP_LO];
    assign rd       = ir[IR_RD_HI:IR_RD_LO];
    assign rs       = ir[IR_RS_HI:IR_RS_LO];
    assign imm      = ir[IR_IMM_HI:IR_IMM_LO];

    uc_regfile #(
        .WIDTH(WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rd),
        .rdata_a (rdata_a),
        .raddr_b (rs),
        .rdata_b (rdata_b),
        .we      (reg_we),
        .waddr   (rd),
        .wdata   (reg_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC:   state_next = (!is_alu && ir_class == CLS_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_load      = (state == ST_FETCH) && imem_ack;
        alu_load     = (state == ST_DECODE) && is_alu;
        exec_en      = (state == ST_EXEC);
        halted       = (state == ST_HALT);
        imem_addr    = pc;
        branch_taken = 1'b0;
        reg_we       = 1'b0;
        reg_wdata    = alu_result;
        z_we         = 1'b0;
        c_we         = 1'b0;
        out_fire     = 1'b0;
        if (exec_en) begin
            if (is_alu) begin
                reg_we = alu_writes_rd(ir_op);
                z_we   = (ir_op == OP_CMP);
                c_we   = (ir_op == OP_ADD);
            end else begin
                unique case (ir_class)
                    CLS_LDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = WIDTH'(imm);
                    end
                    CLS_JMP: branch_taken = 1'b1;
                    CLS_JZ:  branch_taken = flag_z;
                    CLS_JC:  branch_taken = flag_c;
                    CLS_OUT: out_fire     = 1'b1;
                    default: ;
                endcase
            end
        end
        pc_next = branch_taken ? PC_WIDTH'(imm) : pc + PC_WIDTH'(1);
    end

    // imem_req is registered off the next state so it is high exactly in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req   <= 1'b0;
            ir         <= '0;
            pc         <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            imem_req  <= (state_next == ST_FETCH);
            out_valid <= 1'b0;
            if (ir_load) begin
                ir <= imem_rdata;
            end
            if (alu_load) begin
                alu_a      <= rdata_a;
                alu_b      <= rdata_b;
                alu_opcode <= OPCODE_WIDTH'(ir_op);
            end
            if (exec_en) begin
                pc <= pc_next;
                if (z_we) flag_z <= alu_equal;
                if (c_we) flag_c <= alu_carry;
                if (out_fire) begin
                    out_valid <= 1'b1;
                    out_data  <= rdata_b;
                end
            end
        end
    end

endmodule

// File: doc/uc_control_unit.md
# uc_control_unit

Instruction fetch/decode/execute controller for the 8-bit microcontroller; the block that drives the ALU's `a`, `b` and `opcode` inputs and consumes its `result`, `equal_out` and `carry_out`. It fetches 16-bit instructions over a req/ack memory interface and holds a 4×8 register file, a program counter and Z/C flags. It sequences each instruction through a fixed FSM, writes results back and resolves branches.

## Interface
- `WIDTH`, 8: datapath / register width
- `OPCODE_WIDTH`, 3: ALU opcode width
- `PC_WIDTH`, 8: program counter / instruction address width
- `clk` input 1: clock, rising edge
- `rst_n` input 1: reset; asynchronous and active-low
- `imem_req` output 1: fetch request, registered
- `imem_addr` output PC_WIDTH: fetch address (= PC)
- `imem_rdata` input 16: instruction word, valid when `imem_ack`=1
- `imem_ack` input 1: fetch complete; ignored unless `imem_req`=1
- `alu_a`, `alu_b` output WIDTH: ALU operands, registered
- `alu_opcode` output OPCODE_WIDTH: ALU opcode, registered
- `alu_result` input WIDTH; `alu_equal` input 1; `alu_carry` input 1: ALU outputs, combinational from `alu_a`/`alu_b`/`alu_opcode`
- `out_data` output WIDTH; `out_valid` output 1: OUT instruction port, one-cycle pulse
- `halted` output 1: high in HALT state

## Operation
- Encoding:
  - `ir[15]`=0: ALU op. `alu_opcode`=`ir[14:12]`, rd=`ir[11:10]`, rs=`ir[9:8]`, a=R[rd], b=R[rs]. Result written to rd, except opcode 101 (CMP), which writes no register.
  - `ir[15:12]`: 1000 LDI rd,`ir[7:0]`; 1001 JMP `ir[7:0]`; 1010 JZ; 1011 JC; 1100 OUT R[rs]; 1111 HALT; 1101/1110 NOP.
- Flags:
  - Z <= `alu_equal` only on CMP.
  - C <= `alu_carry` only on ADD (000).
  - All other instructions leave both flags unchanged.
- PC:
  - PC+1 after every non-taken instruction.
  - Taken JMP/JZ/JC load `ir[7:0]`.
  - Wraps 0xFF→0x00.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE→FETCH unconditionally; sets `imem_req`.
  - FETCH: hold `imem_req`=1 and `imem_addr` stable until `imem_ack`. On ack, latch `ir`, clear req, →DECODE.
  - DECODE: register `alu_a`/`alu_b`/`alu_opcode` (ALU ops only; otherwise hold previous values), →EXEC.
  - EXEC: sample ALU outputs, write back, update flags/PC, pulse OUT. →FETCH (req set), or →HALT on HALT.
  - HALT: terminal until reset; `imem_req`=0.
- Reset values: state IDLE; PC, R0–R3, Z, C, `ir` = 0; `imem_req`=0, `imem_addr`=0x00, `alu_a`/`alu_b`/`alu_opcode`=0, `out_data`=0, `out_valid`=0, `halted`=0.

## Timing
- Zero-wait memory (ack in the first FETCH cycle): 3 cycles per instruction (FETCH, DECODE, EXEC).
- Each ack wait cycle adds one cycle.
- First `imem_req` is asserted 1 cycle after reset release (IDLE cycle), with `imem_addr`=0x00.
- Register write, flag update and PC update take effect at the clock edge ending EXEC. The next instruction sees them in its DECODE.
- `out_valid`/`out_data` are registered and asserted in the cycle after EXEC, for exactly 1 cycle.
- `imem_ack` while `imem_req`=0 (IDLE/DECODE/EXEC/HALT): ignored, no state change.
- Reset asserted mid-instruction: all outputs return to reset values immediately (asynchronous). The pending write, flag update and OUT are discarded. Restart is from IDLE.

## Structure
- Package `uc_pkg`:
  - FSM state enum.
  - Instruction class constants (LDI, JMP, JZ, JC, OUT, HALT).
  - ALU opcode constants: ADD 000, SUB 001, AND 010, OR 011, NOT 100, CMP 101, SHL 110, SHR 111.
  - Field bit positions.
- Sub-module `uc_regfile`: 4×`WIDTH` registers, 2 combinational read ports, 1 synchronous write port, async active-low reset to 0.

## Test plan
- LDI R0,0x05 (0x8005); LDI R1,0x03 (0x8403); ADD R0,R1 (0x0100); OUT R0 (0xC000) -> `out_data`=0x08 with 1-cycle `out_valid`; C=0; fetches at 0x00..0x03 spaced 3 cycles apart.
- R0=0xFF, R1=0x01; ADD (0x0100); JC 0x20 (0xB020) -> R0=0x00, C=1; next `imem_addr`=0x20.
- R0=R1=0x3C; CMP (0x5100); JZ 0x40 (0xA040) -> R0 stays 0x3C, Z=1, next fetch at 0x40. Repeat with R1=0x3D -> Z=0, next fetch at PC+1.
- `imem_ack` delayed 4 cycles -> `imem_req`=1 and `imem_addr` constant throughout the wait; instruction completes exactly 4 cycles later than zero-wait. A spurious ack during DECODE has no effect.
- JMP 0xFF (0x90FF) with NOP (0xD000) at 0xFF -> next fetch at 0x00. HALT (0xF000) -> `halted`=1, `imem_req` stays 0 for 20+ cycles.
- Assert `rst_n`=0 during EXEC of ADD -> outputs at reset values immediately, no writeback. After release: IDLE, then fetch at 0x00.
